seg7_bcd_scan: RTL and testbench

Consumer end of the push-button path: takes the one-cycle press pulses produced by the button debouncers and turns them into a 4-digit BCD up/down count. It drives that count onto a common-anode 4-digit 7-segment display by time-multiplexing the digits. It sits between the debouncer outputs and the board's segment/digit pins.

---
 rtl/seg7_bcd_scan.sv | 145 ++++++++++++++
 tb/tb_seg7_bcd_scan.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seg7_bcd_scan                                                    |
// | Purpose : 4-digit BCD up/down counter with multiplexed common-anode        |
// |           7-segment drive. Optional SEG7_LEADING_ZERO_BLANK_EN blanks      |
// |           leading zero digits (digit 0 always shown).                      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module seg7_bcd_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iInc,
  input  logic        iDec,
  input  logic        iClr,
  output logic [15:0] oValue,
  output logic        oWrap,
  output logic [3:0]  oDig_n,
  output logic [6:0]  oSeg_n
);

  localparam logic [19:0] c_DIV_LAST = 20'(SCAN_DIV - 1);

  logic [15:0] r_value;
  logic        r_wrap;
  logic [19:0] r_div;
  logic [1:0]  r_idx;
  logic [3:0]  r_dig;
  logic [6:0]  r_seg;

  logic [15:0] w_incVal;
  logic [15:0] w_decVal;
  logic        w_incCarry;
  logic        w_decBorrow;
  logic [3:0]  w_curDigit;
  logic [6:0]  w_segDec;
  logic [6:0]  w_segNext;

  // Digit-serial decimal increment; a carry out of digit 3 means 9999 wrapped.
  always_comb begin
    w_incVal   = r_value;
    w_incCarry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_incCarry) begin
        if (r_value[4*i +: 4] == 4'd9) begin
          w_incVal[4*i +: 4] = 4'd0;
        end else begin
          w_incVal[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
          w_incCarry         = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_decVal    = r_value;
    w_decBorrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_decBorrow) begin
        if (r_value[4*i +: 4] == 4'd0) begin
          w_decVal[4*i +: 4] = 4'd9;
        end else begin
          w_decVal[4*i +: 4] = r_value[4*i +: 4] - 4'd1;
          w_decBorrow        = 1'b0;
        end
      end
    end
  end

  assign w_curDigit = r_value[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_segDec = 7'h7F;
    case (w_curDigit)
      4'd0:    w_segDec = 7'h40;
      4'd1:    w_segDec = 7'h79;
      4'd2:    w_segDec = 7'h24;
      4'd3:    w_segDec = 7'h30;
      4'd4:    w_segDec = 7'h19;
      4'd5:    w_segDec = 7'h12;
      4'd6:    w_segDec = 7'h02;
      4'd7:    w_segDec = 7'h78;
      4'd8:    w_segDec = 7'h00;
      4'd9:    w_segDec = 7'h10;
      default: w_segDec = 7'h7F;
    endcase
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic w_blank;
  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd3:    w_blank = (r_value[15:12] == 4'd0);
      2'd2:    w_blank = (r_value[15:8]  == 8'd0);
      2'd1:    w_blank = (r_value[15:4]  == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end
  assign w_segNext = w_blank ? 7'h7F : w_segDec;
`else
  assign w_segNext = w_segDec;
`endif

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_value <= 16'h0000;
      r_wrap  <= 1'b0;
      r_div   <= 20'd0;
      r_idx   <= 2'd0;
      r_dig   <= 4'hF;
      r_seg   <= 7'h7F;
    end else begin
      r_dig <= ~(4'b0001 << r_idx);
      r_seg <= w_segNext;

      if (r_div == c_DIV_LAST) begin
        r_div <= 20'd0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_div <= r_div + 20'd1;
      end

      r_wrap <= 1'b0;
      if (iClr) begin
        r_value <= 16'h0000;
      end else if (iInc && !iDec) begin
        r_value <= w_incVal;
        r_wrap  <= w_incCarry;
      end else if (iDec && !iInc) begin
        r_value <= w_decVal;
        r_wrap  <= w_decBorrow;
      end
    end
  end

  assign oValue = r_value;
  assign oWrap  = r_wrap;
  assign oDig_n = r_dig;
  assign oSeg_n = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg7_bcd_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_seg7_bcd_scan                                                 |
// | Purpose : Randomized self-checking bench for seg7_bcd_scan against an      |
// |           integer-arithmetic reference model.                              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_seg7_bcd_scan;

  localparam int SD = 4;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iInc;
  logic        iDec;
  logic        iClr;
  logic [15:0] oValue;
  logic        oWrap;
  logic [3:0]  oDig_n;
  logic [6:0]  oSeg_n;

  int nChecks = 0;
  int nFails  = 0;

  int         mVal;
  bit         mWrap;
  int         mTicks;
  logic [3:0] mDig;
  logic [6:0] mSeg;

  logic [6:0] segTab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int         pow10 [4]   = '{1, 10, 100, 1000};

  seg7_bcd_scan #(.SCAN_DIV(SD)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iInc   (iInc),
    .iDec   (iDec),
    .iClr   (iClr),
    .oValue (oValue),
    .oWrap  (oWrap),
    .oDig_n (oDig_n),
    .oSeg_n (oSeg_n)
  );

  always #5 iClk = ~iClk;

  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10[i]) % 10);
    return r;
  endfunction

  function automatic logic [6:0] segOf(input int v, input int idx);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (idx > 0 && v < pow10[idx]) return 7'h7F;
`endif
    return segTab[(v / pow10[idx]) % 10];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input bit inc, input bit dec, input bit clr, input bit rstn);
    int idx;
    iInc = inc; iDec = dec; iClr = clr; iRst_n = rstn;
    @(posedge iClk);
    if (!rstn) begin
      mVal = 0; mWrap = 0; mTicks = 0; mDig = 4'hF; mSeg = 7'h7F;
    end else begin
      idx    = (mTicks / SD) % 4;
      mDig   = ~(4'b0001 << idx);
      mSeg   = segOf(mVal, idx);
      mTicks = (mTicks + 1) % (4 * SD);
      mWrap  = 0;
      if (clr) mVal = 0;
      else if (inc && !dec) begin
        if (mVal == 9999) begin mVal = 0; mWrap = 1; end else mVal++;
      end else if (dec && !inc) begin
        if (mVal == 0) begin mVal = 9999; mWrap = 1; end else mVal--;
      end
    end
    #1;
    chk("value", 32'(oValue), 32'(toBcd(mVal)));
    chk("wrap",  32'(oWrap),  32'(mWrap));
    chk("dig",   32'(oDig_n), 32'(mDig));
    chk("seg",   32'(oSeg_n), 32'(mSeg));
  endtask

  initial begin
    logic [3:0] expDig;
    int         guard;
    iInc = 0; iDec = 0; iClr = 0; iRst_n = 0;

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_value", 32'(oValue), 32'h0000);
    chk("rst_dig",   32'(oDig_n), 32'hF);
    chk("rst_seg",   32'(oSeg_n), 32'h7F);

    // Scan order with 4-cycle slots: E x4, D x4, B x4, 7 x4.
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 1);
      expDig = ~(4'b0001 << (k / SD));
      chk("scan_dig", 32'(oDig_n), 32'(expDig));
      chk("scan_seg", 32'(oSeg_n), 32'h40);
    end

    repeat (12) step(1, 0, 0, 1);
    chk("inc12", 32'(oValue), 32'h0012);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 1);
      if (oDig_n == 4'hE) chk("d0_seg", 32'(oSeg_n), 32'h24);
      if (oDig_n == 4'hD) chk("d1_seg", 32'(oSeg_n), 32'h79);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (oDig_n == 4'hB || oDig_n == 4'h7) chk("hi_seg", 32'(oSeg_n), 32'h7F);
`else
      if (oDig_n == 4'hB || oDig_n == 4'h7) chk("hi_seg", 32'(oSeg_n), 32'h40);
`endif
    end

    step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    chk("dec_wrap_val", 32'(oValue), 32'h9999);
    chk("dec_wrap",     32'(oWrap),  32'h1);
    step(0, 0, 0, 1);
    chk("dec_wrap_end", 32'(oWrap),  32'h0);
    step(1, 0, 0, 1);
    chk("inc_wrap_val", 32'(oValue), 32'h0000);
    chk("inc_wrap",     32'(oWrap),  32'h1);
    step(0, 0, 0, 1);
    chk("inc_wrap_end", 32'(oWrap),  32'h0);

    step(0, 0, 1, 1);
    repeat (512) step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    chk("both_val",  32'(oValue), 32'h0512);
    chk("both_wrap", 32'(oWrap),  32'h0);
    step(1, 1, 1, 1);
    chk("all_val",   32'(oValue), 32'h0000);
    chk("all_wrap",  32'(oWrap),  32'h0);

    repeat (995) step(1, 0, 0, 1);
    chk("at995", 32'(oValue), 32'h0995);
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0, 1);
      if (k == 4) chk("ripple1000", 32'(oValue), 32'h1000);
    end
    chk("held1005", 32'(oValue), 32'h1005);

    step(0, 0, 1, 1);
    repeat (4321) step(1, 0, 0, 1);
    guard = 0;
    while (!(((mTicks / SD) % 4) == 2 && (mTicks % SD) == 1) && guard < 32) begin
      step(0, 0, 0, 1);
      guard++;
    end
    chk("slot2_reached", 32'(guard < 32), 32'h1);
    chk("pre_rst_val",   32'(oValue), 32'h4321);
    step(0, 0, 0, 0);
    chk("midrst_val", 32'(oValue), 32'h0000);
    chk("midrst_dig", 32'(oDig_n), 32'hF);
    chk("midrst_seg", 32'(oSeg_n), 32'h7F);
    step(0, 0, 0, 1);
    chk("post_dig", 32'(oDig_n), 32'hE);
    chk("post_seg", 32'(oSeg_n), 32'h40);

    for (int k = 0; k < 3000; k++) begin
      int r;
      r = $urandom_range(0, 199);
      step(($urandom % 3) == 0, ($urandom % 3) == 0, r < 6, r != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
